systolic_ctrl: RTL

- Sequencer for the weight-stationary systolic array.
- On a start command it performs three steps:
  - loads one weight per column (walking one-hot `weight_en`);
  - streams `num_vec` feature vectors with per-row skewed `in_en` enables;
  - drains the pipeline and flags which column outputs are valid each cycle.
- Sits between the layer-level scheduler (start/config/done) and the array plus its weight/feature buffers (read strobes).

---
 rtl/systolic_pkg.sv | 30 +++
 rtl/skew_window.sv | 22 ++
 rtl/systolic_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the weight-stationary systolic array sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } sys_state_t;

    // Array geometry defaults, shared with the array top level.
    localparam int DEF_ROW    = 4;
    localparam int DEF_COL    = 4;
    localparam int DEF_VEC_W  = 8;
    localparam int DEF_PE_LAT = 1;

    // Stream-step counter width: covers N_max + fill + drain without wrapping.
    function automatic int s_cnt_w(input int vec_w, input int row, input int col,
                                   input int pe_lat);
        return vec_w + $clog2(row + col + pe_lat) + 1;
    endfunction

    // Index width that stays at least one bit wide for single-lane arrays.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skew_window.sv
// Per-lane skewed window: win[i] = (s - BASE - i) lies in [0, n).
// Latency: combinational from the step counter and the latched vector count.
// Backpressure: none; pure decode.
// Ports: s = stream step, n = vectors in job, win = one bit per lane.
module skew_window #(
    parameter int LANES = 4,
    parameter int SW    = 13,
    parameter int NW    = 8,
    parameter int BASE  = 0
) (
    input  logic [SW-1:0]    s,
    input  logic [NW-1:0]    n,
    output logic [LANES-1:0] win
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int LO = BASE + i;
        // Lower bound test first so the subtraction never underflows when it matters.
        assign win[i] = (s >= SW'(LO)) && ((s - SW'(LO)) < SW'(n));
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the weight-stationary array: weight load, skewed feature stream, drain.
// Latency: job takes COL + (N+ROW+COL+PE_LAT-2) + 1 busy cycles after an accepted start.
// Backpressure: none; start is dropped while busy, abort ends the job via DONE.
// Ports: clk_in/rst_in (sync, active-high); start_in/num_vec_in/abort_in from the scheduler;
//        ctrl_out/weight_en/in_en to the array; w_rd_en/w_col_idx/f_rd_en to buffers;
//        out_valid marks valid column results; busy/done back to the scheduler.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ROW    = DEF_ROW,
    parameter int COL    = DEF_COL,
    parameter int VEC_W  = DEF_VEC_W,
    parameter int PE_LAT = DEF_PE_LAT,
    parameter int KW     = idx_w(COL)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [VEC_W-1:0] num_vec_in,
    input  logic             abort_in,
    output logic             ctrl_out,
    output logic [COL-1:0]   weight_en,
    output logic             w_rd_en,
    output logic [KW-1:0]    w_col_idx,
    output logic [ROW-1:0]   in_en,
    output logic [ROW-1:0]   f_rd_en,
    output logic [COL-1:0]   out_valid,
    output logic             busy,
    output logic             done
);

    localparam int SW = s_cnt_w(VEC_W, ROW, COL, PE_LAT);
    localparam int T0 = ROW - 1 + PE_LAT;

    sys_state_t       state;
    sys_state_t       state_nxt;
    logic [KW-1:0]    k;
    logic [SW-1:0]    s;
    logic [VEC_W-1:0] n_lat;
    logic [SW-1:0]    s_last;
    logic [ROW-1:0]   in_win;
    logic [COL-1:0]   out_win;

    // Final stream step is the last cycle column COL-1 holds a valid result.
    assign s_last = SW'(n_lat) + SW'(ROW + COL + PE_LAT - 3);

    skew_window #(.LANES(ROW), .SW(SW), .NW(VEC_W), .BASE(0)) u_in_win (
        .s   (s),
        .n   (n_lat),
        .win (in_win)
    );

    skew_window #(.LANES(COL), .SW(SW), .NW(VEC_W), .BASE(T0)) u_out_win (
        .s   (s),
        .n   (n_lat),
        .win (out_win)
    );

    // State and counter registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            k     <= '0;
            s     <= '0;
            n_lat <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (state_nxt == LOAD_W) begin
                        n_lat <= num_vec_in;
                        k     <= '0;
                        s     <= '0;
                    end
                end
                LOAD_W:  k <= k + KW'(1);
                STREAM:  s <= s + SW'(1);
                default: ;
            endcase
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A zero-length job is treated as no request at all.
                if (start_in && (num_vec_in != '0)) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                if (abort_in)                     state_nxt = DONE;
                else if (k == KW'(COL - 1))       state_nxt = STREAM;
            end
            STREAM: begin
                if (abort_in)                     state_nxt = DONE;
                else if (s == s_last)             state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode only from registered state and counters, never from inputs.
    always_comb begin
        ctrl_out  = 1'b0;
        weight_en = '0;
        w_col_idx = '0;
        in_en     = '0;
        out_valid = '0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            LOAD_W: begin
                ctrl_out  = 1'b1;
                weight_en = COL'(1) << k;
                w_col_idx = k;
            end
            STREAM: begin
                in_en     = in_win;
                out_valid = out_win;
            end
            default: ;
        endcase
    end

    assign w_rd_en = |weight_en;
    assign f_rd_en = in_en;

endmodule
